// File: rtl/ahb_sram_pkg.sv
// ahb_sram_pkg: shared encodings and byte-enable helpers for the
// AHB-Lite to synchronous SRAM bridge.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic {
    ERR_OKAY,
    ERR_ERR1
  } err_state_t;

  // Little-endian lane enables; sizes above half are treated as word.
  function automatic logic [3:0] be_decode(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'hf;
    unique case (1'b1)
      (size == HSIZE_BYTE): be = 4'b0001 << a;
      (size == HSIZE_HALF): be = a[1] ? 4'b1100 : 4'b0011;
      default:              be = 4'hf;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (size == HSIZE_BYTE): m = 1'b0;
      (size == HSIZE_HALF): m = a[0];
      default:              m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// ahb_sram_wbuf: one-entry write buffer; commits to SRAM when no read
// owns the port and merges buffered bytes into read data per lane.
import ahb_sram_pkg::*;

module ahb_sram_wbuf #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap,
  input  logic [AW-1:0] cap_addr,
  input  logic [3:0]    cap_be,
  input  logic [31:0]   cap_data,
  input  logic          hold,
  input  logic [AW-1:0] rd_addr,
  input  logic [31:0]   sram_rdata,
  output logic          commit,
  output logic [AW-1:0] buf_addr,
  output logic [3:0]    buf_be,
  output logic [31:0]   buf_data,
  output logic [31:0]   fwd_data
);

  logic vld;
  logic hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= 1'b0;
      buf_addr <= '0;
      buf_be   <= '0;
      buf_data <= '0;
    end else if (cap) begin
      // A capture may coincide with a commit of the old entry.
      vld      <= 1'b1;
      buf_addr <= cap_addr;
      buf_be   <= cap_be;
      buf_data <= cap_data;
    end else if (commit) begin
      vld <= 1'b0;
    end
  end

  assign commit = vld & ~hold;
  assign hit    = vld & (buf_addr == rd_addr);

  always_comb begin
    fwd_data = sram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (hit && buf_be[i]) begin
        fwd_data[8*i +: 8] = buf_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ahb_sram_bridge.sv
// ahb_sram_bridge: zero-wait AHB-Lite slave onto single-port SRAM.
// Optional AHB_SRAM_ERR_EN: two-cycle ERROR on unaligned transfers.
import ahb_sram_pkg::*;

module ahb_sram_bridge #(
  parameter int AW = 12
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP,
  output logic [AW-1:0] SRAMADDR,
  output logic          SRAMCS,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  input  logic [31:0]   SRAMRDATA
);

  logic          accept;
  logic          err_ap;
  logic          rd_ap;
  logic          wr_ap;
  logic          cap;
  logic [AW-1:0] haddr_w;
  logic [3:0]    hbe;

  logic          pend;
  logic [AW-1:0] pend_addr;
  logic [3:0]    pend_be;
  logic          rd_dp;
  logic [AW-1:0] rd_addr;

  logic          commit;
  logic [AW-1:0] buf_addr;
  logic [3:0]    buf_be;
  logic [31:0]   buf_data;
  logic [31:0]   fwd_data;

  logic          unused;

  assign accept  = HSEL & HTRANS[1] & HREADY;
  assign haddr_w = HADDR[AW+1:2];
  assign hbe     = be_decode(HSIZE, HADDR[1:0]);
  assign rd_ap   = accept & ~HWRITE & ~err_ap;
  assign wr_ap   = accept & HWRITE & ~err_ap;
  assign cap     = pend & HREADY;
  assign unused  = ^{HADDR[31:AW+2], HTRANS[0]};

`ifdef AHB_SRAM_ERR_EN
  err_state_t state;
  err_state_t state_nx;
  logic       err2;

  assign err_ap = accept & misaligned(HSIZE, HADDR[1:0]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ERR_OKAY;
      err2  <= 1'b0;
    end else begin
      state <= state_nx;
      err2  <= (state == ERR_ERR1);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ERR_OKAY: if (err_ap) state_nx = ERR_ERR1;
      ERR_ERR1: state_nx = ERR_OKAY;
      default:  state_nx = ERR_OKAY;
    endcase
  end

  // Second error cycle is flagged by err2 after ERR1 drops.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = err2;
    if (state == ERR_ERR1) begin
      HREADYOUT = 1'b0;
      HRESP     = 1'b1;
    end
  end
`else
  assign err_ap    = 1'b0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_be   <= '0;
      rd_dp     <= 1'b0;
      rd_addr   <= '0;
    end else if (HREADY) begin
      pend  <= wr_ap;
      rd_dp <= rd_ap;
      if (wr_ap) begin
        pend_addr <= haddr_w;
        pend_be   <= hbe;
      end
      if (rd_ap) begin
        rd_addr <= haddr_w;
      end
    end
  end

  ahb_sram_wbuf #(
    .AW(AW)
  ) u_wbuf (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .cap       (cap),
    .cap_addr  (pend_addr),
    .cap_be    (pend_be),
    .cap_data  (HWDATA),
    .hold      (rd_ap),
    .rd_addr   (rd_addr),
    .sram_rdata(SRAMRDATA),
    .commit    (commit),
    .buf_addr  (buf_addr),
    .buf_be    (buf_be),
    .buf_data  (buf_data),
    .fwd_data  (fwd_data)
  );

  // Reads own the port; the buffer drains on any other cycle.
  assign SRAMCS    = rd_ap | commit;
  assign SRAMADDR  = rd_ap ? haddr_w : buf_addr;
  assign SRAMWEN   = commit ? buf_be : 4'h0;
  assign SRAMWDATA = buf_data;
  assign HRDATA    = rd_dp ? fwd_data : 32'h0;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// tb_ahb_sram_bridge: directed self-checking bench for ahb_sram_bridge
// with a behavioural synchronous SRAM model.
import ahb_sram_pkg::*;

module tb_ahb_sram_bridge;

  localparam int AW = 12;

  logic          HCLK;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [AW-1:0] SRAMADDR;
  logic          SRAMCS;
  logic [3:0]    SRAMWEN;
  logic [31:0]   SRAMWDATA;
  logic [31:0]   SRAMRDATA;

  logic [31:0] mem [0:(1<<AW)-1];
  int wen_cnt;
  int ovl;
  int total;
  int bad;

  ahb_sram_bridge #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .HRESP(HRESP), .SRAMADDR(SRAMADDR), .SRAMCS(SRAMCS),
    .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA), .SRAMRDATA(SRAMRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    wen_cnt   = 0;
    ovl       = 0;
    SRAMRDATA = 32'h0;
  end

  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'h0) begin
        SRAMRDATA <= mem[SRAMADDR];
      end else begin
        wen_cnt <= wen_cnt + 1;
        for (int i = 0; i < 4; i++)
          if (SRAMWEN[i]) mem[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
      end
    end
    if (HSEL && HTRANS[1] && HREADY && !HWRITE && SRAMWEN != 4'h0)
      ovl <= ovl + 1;
  end

  task automatic put(input logic s, input logic [1:0] t, input logic w,
                     input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd);
    HSEL = s; HTRANS = t; HWRITE = w; HSIZE = sz;
    HADDR = a; HWDATA = wd; HREADY = 1'b1;
  endtask

  task automatic idle(input logic [31:0] wd);
    put(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, wd);
  endtask

  task automatic tick;
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    idle(32'h0);
    repeat (2) tick;
    @(negedge HCLK);
    total++; if (HREADYOUT !== 1'b1) begin bad++; $display("FAIL rst_hreadyout got=%b want=1", HREADYOUT); end
    total++; if (HRESP !== 1'b0) begin bad++; $display("FAIL rst_hresp got=%b want=0", HRESP); end
    total++; if (HRDATA !== 32'h0) begin bad++; $display("FAIL rst_hrdata got=%h want=0", HRDATA); end
    total++; if (SRAMCS !== 1'b0) begin bad++; $display("FAIL rst_sramcs got=%b want=0", SRAMCS); end
    total++; if (SRAMWEN !== 4'h0) begin bad++; $display("FAIL rst_sramwen got=%h want=0", SRAMWEN); end
    tick;
    HRESETn = 1'b1;
    tick;
  endtask

  task automatic test_idle;
    put(1'b1, HTRANS_BUSY, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
    @(negedge HCLK);
    total++; if (SRAMCS !== 1'b0) begin bad++; $display("FAIL busy_cs got=%b want=0", SRAMCS); end
    tick;
    put(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, 32'h0);
    @(negedge HCLK);
    total++; if (SRAMCS !== 1'b0) begin bad++; $display("FAIL unsel_cs got=%b want=0", SRAMCS); end
    tick;
    idle(32'h0);
    @(negedge HCLK);
    total++; if (SRAMCS !== 1'b0) begin bad++; $display("FAIL unsel_nowr got=%b want=0", SRAMCS); end
    total++; if (HREADYOUT !== 1'b1) begin bad++; $display("FAIL idle_rdy got=%b want=1", HREADYOUT); end
    tick;
  endtask

  task automatic test_raw_word;
    put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0);
    tick;
    put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'hdeadbeef);
    @(negedge HCLK);
    total++; if (SRAMCS !== 1'b1 || SRAMWEN !== 4'h0 || SRAMADDR !== 12'h4) begin
      bad++; $display("FAIL raw_rdap got=%b/%h/%h want=1/0/004", SRAMCS, SRAMWEN, SRAMADDR); end
    tick;
    idle(32'h0);
    @(negedge HCLK);
    total++; if (HRDATA !== 32'hdeadbeef) begin bad++; $display("FAIL raw_fwd got=%h want=deadbeef", HRDATA); end
    total++; if (SRAMWEN !== 4'hf || SRAMADDR !== 12'h4 || SRAMWDATA !== 32'hdeadbeef) begin
      bad++; $display("FAIL raw_commit got=%h/%h/%h want=f/004/deadbeef", SRAMWEN, SRAMADDR, SRAMWDATA); end
    tick;
    @(negedge HCLK);
    total++; if (SRAMCS !== 1'b0) begin bad++; $display("FAIL raw_drained got=%b want=0", SRAMCS); end
    total++; if (mem[4] !== 32'hdeadbeef) begin bad++; $display("FAIL raw_mem got=%h want=deadbeef", mem[4]); end
    tick;
  endtask

  task automatic test_byte_merge;
    put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0);
    tick;
    idle(32'h11223344);
    tick;
    put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h13, 32'h0);
    tick;
    put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'haa000000);
    tick;
    idle(32'h0);
    @(negedge HCLK);
    total++; if (HRDATA !== 32'haa223344) begin bad++; $display("FAIL byte_fwd got=%h want=aa223344", HRDATA); end
    total++; if (SRAMWEN !== 4'b1000) begin bad++; $display("FAIL byte_wen got=%b want=1000", SRAMWEN); end
    tick;
    put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h12, 32'h0);
    tick;
    put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'hbeef0000);
    tick;
    idle(32'h0);
    @(negedge HCLK);
    total++; if (HRDATA !== 32'hbeef3344) begin bad++; $display("FAIL half_fwd got=%h want=beef3344", HRDATA); end
    total++; if (SRAMWEN !== 4'b1100) begin bad++; $display("FAIL half_wen got=%b want=1100", SRAMWEN); end
    tick;
    put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    tick;
    idle(32'h0);
    @(negedge HCLK);
    total++; if (HRDATA !== 32'hbeef3344) begin bad++; $display("FAIL merge_sram got=%h want=beef3344", HRDATA); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic rdy_ok;
    rdy_ok = 1'b1;
    put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0, 32'h0);
    tick;
    put(1'b1, HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'h4, 32'ha0a0a0a0);
    @(negedge HCLK); rdy_ok &= (HREADYOUT === 1'b1);
    total++; if (SRAMCS !== 1'b0) begin bad++; $display("FAIL b2b_c2 got=%b want=0", SRAMCS); end
    tick;
    put(1'b1, HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'h8, 32'ha1a1a1a1);
    @(negedge HCLK); rdy_ok &= (HREADYOUT === 1'b1);
    total++; if (SRAMWEN !== 4'hf || SRAMADDR !== 12'h0 || SRAMWDATA !== 32'ha0a0a0a0) begin
      bad++; $display("FAIL b2b_w0 got=%h/%h/%h want=f/000/a0a0a0a0", SRAMWEN, SRAMADDR, SRAMWDATA); end
    tick;
    idle(32'ha2a2a2a2);
    @(negedge HCLK); rdy_ok &= (HREADYOUT === 1'b1);
    total++; if (SRAMWEN !== 4'hf || SRAMADDR !== 12'h1 || SRAMWDATA !== 32'ha1a1a1a1) begin
      bad++; $display("FAIL b2b_w1 got=%h/%h/%h want=f/001/a1a1a1a1", SRAMWEN, SRAMADDR, SRAMWDATA); end
    tick;
    idle(32'h0);
    @(negedge HCLK); rdy_ok &= (HREADYOUT === 1'b1);
    total++; if (SRAMWEN !== 4'hf || SRAMADDR !== 12'h2 || SRAMWDATA !== 32'ha2a2a2a2) begin
      bad++; $display("FAIL b2b_w2 got=%h/%h/%h want=f/002/a2a2a2a2", SRAMWEN, SRAMADDR, SRAMWDATA); end
    tick;
    put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
    tick;
    put(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h4, 32'h0);
    @(negedge HCLK); rdy_ok &= (HREADYOUT === 1'b1);
    total++; if (HRDATA !== 32'ha0a0a0a0) begin bad++; $display("FAIL b2b_r0 got=%h want=a0a0a0a0", HRDATA); end
    tick;
    put(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h8, 32'h0);
    @(negedge HCLK);
    total++; if (HRDATA !== 32'ha1a1a1a1) begin bad++; $display("FAIL b2b_r1 got=%h want=a1a1a1a1", HRDATA); end
    tick;
    idle(32'h0);
    @(negedge HCLK);
    total++; if (HRDATA !== 32'ha2a2a2a2) begin bad++; $display("FAIL b2b_r2 got=%h want=a2a2a2a2", HRDATA); end
    total++; if (rdy_ok !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", rdy_ok); end
    tick;
  endtask

  task automatic test_read_write_read;
    put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
    tick;
    idle(32'hcafef00d);
    tick;
    idle(32'h0);
    tick;
    put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    tick;
    put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
    @(negedge HCLK);
    total++; if (HRDATA !== 32'hcafef00d) begin bad++; $display("FAIL rwr_first got=%h want=cafef00d", HRDATA); end
    tick;
    put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h5);
    tick;
    idle(32'h0);
    @(negedge HCLK);
    total++; if (HRDATA !== 32'h5) begin bad++; $display("FAIL rwr_second got=%h want=00000005", HRDATA); end
    tick;
    idle(32'h0);
    tick;
    total++; if (ovl !== 0) begin bad++; $display("FAIL rwr_overlap got=%0d want=0", ovl); end
    total++; if (mem[8] !== 32'h5) begin bad++; $display("FAIL rwr_mem got=%h want=00000005", mem[8]); end
  endtask

  task automatic test_reset_mid;
    int wen0;
    put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
    tick;
    wen0 = wen_cnt;
    idle(32'hbad0bad0);
    HRESETn = 1'b0;
    @(negedge HCLK);
    total++; if (SRAMCS !== 1'b0 || SRAMWEN !== 4'h0) begin
      bad++; $display("FAIL mid_sram got=%b/%h want=0/0", SRAMCS, SRAMWEN); end
    total++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
      bad++; $display("FAIL mid_bus got=%b/%b/%h want=1/0/0", HREADYOUT, HRESP, HRDATA); end
    tick;
    tick;
    HRESETn = 1'b1;
    idle(32'h0);
    repeat (3) tick;
    total++; if (wen_cnt !== wen0) begin bad++; $display("FAIL mid_nowrite got=%0d want=%0d", wen_cnt, wen0); end
    put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    tick;
    idle(32'h0);
    @(negedge HCLK);
    total++; if (HRDATA !== 32'h5) begin bad++; $display("FAIL mid_orig got=%h want=00000005", HRDATA); end
    tick;
  endtask

  task automatic test_unaligned;
    put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h2, 32'h0);
`ifdef AHB_SRAM_ERR_EN
    @(negedge HCLK);
    total++; if (SRAMCS !== 1'b0) begin bad++; $display("FAIL err_ap_cs got=%b want=0", SRAMCS); end
    tick;
    idle(32'h0);
    HREADY = 1'b0;
    @(negedge HCLK);
    total++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || SRAMCS !== 1'b0) begin
      bad++; $display("FAIL err_c1 got=%b/%b/%b want=0/1/0", HREADYOUT, HRESP, SRAMCS); end
    tick;
    HREADY = 1'b1;
    @(negedge HCLK);
    total++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || SRAMCS !== 1'b0) begin
      bad++; $display("FAIL err_c2 got=%b/%b/%b want=1/1/0", HREADYOUT, HRESP, SRAMCS); end
    tick;
    @(negedge HCLK);
    total++; if (HRESP !== 1'b0 || HRDATA !== 32'h0) begin
      bad++; $display("FAIL err_done got=%b/%h want=0/0", HRESP, HRDATA); end
    tick;
`else
    @(negedge HCLK);
    total++; if (SRAMCS !== 1'b1 || SRAMADDR !== 12'h0) begin
      bad++; $display("FAIL ua_ap got=%b/%h want=1/000", SRAMCS, SRAMADDR); end
    tick;
    idle(32'h0);
    @(negedge HCLK);
    total++; if (HRDATA !== 32'ha0a0a0a0) begin bad++; $display("FAIL ua_data got=%h want=a0a0a0a0", HRDATA); end
    total++; if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
      bad++; $display("FAIL ua_okay got=%b/%b want=0/1", HRESP, HREADYOUT); end
    tick;
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_idle;
    test_raw_word;
    test_byte_merge;
    test_back_to_back;
    test_read_write_read;
    test_reset_mid;
    test_unaligned;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
